// File: rtl/fp_pkg.sv
// Shared constants and helpers for the pipelined floating-point add/subtract unit.
package fp_pkg;

  // Bit positions inside the 4-bit flags word {invalid, overflow, underflow, zero}
  localparam int FLAG_ZERO      = 0;
  localparam int FLAG_UNDERFLOW = 1;
  localparam int FLAG_OVERFLOW  = 2;
  localparam int FLAG_INVALID   = 3;
  localparam int NUM_FLAGS      = 4;

  // Pipeline depth: unpack/align, mantissa add, normalise/round/pack
  localparam int NUM_STAGES = 3;

  // Canonical quiet NaN: sign 0, exponent all-ones, only the fraction MSB set.
  // Returned 64 bits wide; callers truncate to their word width.
  function automatic logic [63:0] canon_nan(input int exp_w, input int man_w);
    logic [63:0] exp_ones;
    exp_ones = (64'd1 << exp_w) - 64'd1;
    return (exp_ones << man_w) | (64'd1 << (man_w - 1));
  endfunction

endpackage

// File: rtl/fp_lzc_shift.sv
// Leading-zero count over an N-bit word plus the matching left shift that
// brings the first set bit to the MSB. An all-zero input reports count N.
module fp_lzc_shift #(
  parameter int N  = 27,
  parameter int CW = $clog2(N + 1)
) (
  input  logic [N-1:0]  din,
  output logic [CW-1:0] count,
  output logic [N-1:0]  dout
);

  // Scan upward so the highest set bit has the final say on the count
  always_comb begin
    count = CW'(N);
    for (int i = 0; i < N; i++) begin
      if (din[i]) count = CW'(N - 1 - i);
    end
    dout = din << count;
  end

endmodule

// File: rtl/fp_addsub_pipe.sv
// Three-stage IEEE-style adder/subtractor with valid/ready handshake.
// S1 unpacks, classifies specials, swaps so the larger magnitude is the base
// and aligns the smaller operand with guard/round/sticky bits. S2 adds or
// subtracts the aligned mantissas. S3 normalises, rounds to nearest-even and
// packs, flushing tiny results to zero. The whole pipe stalls as one unit.
module fp_addsub_pipe
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [EXP_W+MAN_W:0]         a,
  input  logic [EXP_W+MAN_W:0]         b,
  input  logic                         sub,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [EXP_W+MAN_W:0]         result,
  output logic [NUM_FLAGS-1:0]         flags
);

  localparam int W  = 1 + EXP_W + MAN_W;
  // hidden bit + fraction + guard/round/sticky
  localparam int FW = MAN_W + 4;
  localparam int LW = $clog2(FW + 1);
  // signed exponent workspace, wide enough for +carry/+round and -lzc
  localparam int XW = ((EXP_W > LW) ? EXP_W : LW) + 2;
  localparam logic [W-1:0]     QNAN     = W'(canon_nan(EXP_W, MAN_W));
  localparam logic [EXP_W-1:0] EXP_ONES = '1;

  logic                  adv;
  logic [NUM_STAGES-1:0] vld;

  assign adv       = !(out_valid && !out_ready);
  assign in_ready  = adv;
  assign out_valid = vld[NUM_STAGES-1];

  // ---------------- S1: unpack / classify / swap / align ----------------
  logic             s_a, s_b, z_a, z_b, inf_a, inf_b, nan_a, nan_b, a_big;
  logic [EXP_W-1:0] e_a, e_b;
  logic [MAN_W-1:0] f_a, f_b;
  logic [W-2:0]     mag_a, mag_b;

  assign s_a   = a[W-1];
  assign s_b   = b[W-1] ^ sub;
  assign e_a   = a[W-2:MAN_W];
  assign e_b   = b[W-2:MAN_W];
  assign f_a   = a[MAN_W-1:0];
  assign f_b   = b[MAN_W-1:0];
  assign z_a   = (e_a == '0);
  assign z_b   = (e_b == '0);
  assign inf_a = (e_a == EXP_ONES) && (f_a == '0);
  assign inf_b = (e_b == EXP_ONES) && (f_b == '0);
  assign nan_a = (e_a == EXP_ONES) && (f_a != '0);
  assign nan_b = (e_b == EXP_ONES) && (f_b != '0);
  // denormals compare as zero magnitude
  assign mag_a = z_a ? '0 : a[W-2:0];
  assign mag_b = z_b ? '0 : b[W-2:0];
  assign a_big = (mag_a >= mag_b);

  logic             c1_sign, c1_eff_sub, c1_spec, big_z, small_z, lost;
  logic [EXP_W-1:0] c1_exp, small_exp, shamt;
  logic [MAN_W-1:0] big_frac, small_frac;
  logic [FW-1:0]    c1_big, c1_small, small_ext;
  logic [W-1:0]     c1_spec_res;
  logic [NUM_FLAGS-1:0] c1_spec_flags;

  // Swap, align the smaller operand and resolve special-operand outcomes
  always_comb begin
    c1_sign    = a_big ? s_a : s_b;
    c1_exp     = a_big ? e_a : e_b;
    small_exp  = a_big ? e_b : e_a;
    big_frac   = a_big ? f_a : f_b;
    small_frac = a_big ? f_b : f_a;
    big_z      = a_big ? z_a : z_b;
    small_z    = a_big ? z_b : z_a;
    c1_eff_sub = (s_a != s_b);
    c1_big     = big_z ? '0 : {1'b1, big_frac, 3'b000};
    small_ext  = small_z ? '0 : {1'b1, small_frac, 3'b000};
    shamt      = c1_exp - small_exp;
    lost       = 1'b0;
    if (32'(shamt) >= FW - 1) begin
      c1_small = FW'(|small_ext);
    end else begin
      lost     = |(small_ext & ~({FW{1'b1}} << shamt));
      c1_small = (small_ext >> shamt) | FW'(lost);
    end

    c1_spec       = 1'b0;
    c1_spec_res   = '0;
    c1_spec_flags = '0;
    if (nan_a || nan_b || (inf_a && inf_b && (s_a != s_b))) begin
      c1_spec                     = 1'b1;
      c1_spec_res                 = QNAN;
      c1_spec_flags[FLAG_INVALID] = 1'b1;
    end else if (inf_a) begin
      c1_spec     = 1'b1;
      c1_spec_res = {s_a, EXP_ONES, {MAN_W{1'b0}}};
    end else if (inf_b) begin
      c1_spec     = 1'b1;
      c1_spec_res = {s_b, EXP_ONES, {MAN_W{1'b0}}};
    end else if (z_a && z_b) begin
      // -0 survives only when both effective operands are -0
      c1_spec                  = 1'b1;
      c1_spec_res              = {s_a & s_b, {(W-1){1'b0}}};
      c1_spec_flags[FLAG_ZERO] = 1'b1;
    end
  end

  logic                 s1_sign, s1_eff_sub, s1_spec;
  logic [EXP_W-1:0]     s1_exp;
  logic [FW-1:0]        s1_big, s1_small;
  logic [W-1:0]         s1_spec_res;
  logic [NUM_FLAGS-1:0] s1_spec_flags;

  // ---------------- S2: mantissa add/subtract ----------------
  // After the swap the base is never smaller, so the difference stays non-negative
  logic [FW:0] c2_sum;
  assign c2_sum = s1_eff_sub ? ({1'b0, s1_big} - {1'b0, s1_small})
                             : ({1'b0, s1_big} + {1'b0, s1_small});

  logic                 s2_sign, s2_spec;
  logic [EXP_W-1:0]     s2_exp;
  logic [FW:0]          s2_sum;
  logic [W-1:0]         s2_spec_res;
  logic [NUM_FLAGS-1:0] s2_spec_flags;

  // Datapath registers carry no reset; the valid bits qualify them
  always_ff @(posedge clk) begin
    if (adv) begin
      s1_sign       <= c1_sign;
      s1_exp        <= c1_exp;
      s1_big        <= c1_big;
      s1_small      <= c1_small;
      s1_eff_sub    <= c1_eff_sub;
      s1_spec       <= c1_spec;
      s1_spec_res   <= c1_spec_res;
      s1_spec_flags <= c1_spec_flags;
      s2_sign       <= s1_sign;
      s2_exp        <= s1_exp;
      s2_sum        <= c2_sum;
      s2_spec       <= s1_spec;
      s2_spec_res   <= s1_spec_res;
      s2_spec_flags <= s1_spec_flags;
    end
  end

  // ---------------- S3: normalise / round / pack ----------------
  logic [LW-1:0] lz_cnt;
  logic [FW-1:0] lz_dout;

  fp_lzc_shift #(.N(FW), .CW(LW)) u_lzc (
    .din   (s2_sum[FW-1:0]),
    .count (lz_cnt),
    .dout  (lz_dout)
  );

  logic                 carry, round_up, neg, hi;
  logic [LW-1:0]        sh;
  logic [FW-1:0]        norm;
  logic [MAN_W:0]       frac_r;
  logic [XW-1:0]        exp_n;
  logic [EXP_W-1:0]     lo;
  logic [W-1:0]         res_c;
  logic [NUM_FLAGS-1:0] fl_c;

  // Normalise (right on carry-out, left by lzc otherwise), round, then range-check
  always_comb begin
    carry = s2_sum[FW];
    if (carry) begin
      norm = {s2_sum[FW:2], |s2_sum[1:0]};
      sh   = '0;
    end else begin
      norm = lz_dout;
      sh   = lz_cnt;
    end
    round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
    frac_r   = {1'b0, norm[FW-2:3]} + (MAN_W+1)'(round_up);
    exp_n    = XW'(s2_exp) + XW'(carry) + XW'(frac_r[MAN_W]) - XW'(sh);
    neg      = exp_n[XW-1];
    hi       = |exp_n[XW-2:EXP_W];
    lo       = exp_n[EXP_W-1:0];

    res_c = '0;
    fl_c  = '0;
    if (s2_spec) begin
      res_c = s2_spec_res;
      fl_c  = s2_spec_flags;
    end else if (!norm[FW-1]) begin
      // exact cancellation gives +0
      fl_c[FLAG_ZERO] = 1'b1;
    end else if (neg || (!hi && (lo == '0))) begin
      res_c                = {s2_sign, {(W-1){1'b0}}};
      fl_c[FLAG_UNDERFLOW] = 1'b1;
      fl_c[FLAG_ZERO]      = 1'b1;
    end else if (hi || (&lo)) begin
      res_c               = {s2_sign, EXP_ONES, {MAN_W{1'b0}}};
      fl_c[FLAG_OVERFLOW] = 1'b1;
    end else begin
      res_c = {s2_sign, lo, frac_r[MAN_W-1:0]};
    end
  end

  // Stage valids and output registers; output only reloads when real data arrives
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld    <= '0;
      result <= '0;
      flags  <= '0;
    end else if (adv) begin
      vld <= {vld[NUM_STAGES-2:0], in_valid};
      if (vld[NUM_STAGES-2]) begin
        result <= res_c;
        flags  <= fl_c;
      end
    end
  end

endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Scoreboard bench for fp_addsub_pipe (single precision): directed vectors with
// hand-computed results, backpressure and mid-flight reset scenarios.
module tb_fp_addsub_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        sub = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic [3:0]  flags;

  always #5 clk = ~clk;

  fp_addsub_pipe #(.EXP_W(8), .MAN_W(23)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags)
  );

  typedef struct {
    logic [31:0] res;
    logic [3:0]  fl;
    int          stamp;
    bit          lat;
    int          id;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   accepts = 0;
  int   next_id = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, got, want);
    end
  endtask

  // Present one operand pair, wait (bounded) for acceptance, log the expectation
  task automatic send(input logic [31:0] ta, input logic [31:0] tb2, input logic ts,
                      input logic [31:0] er, input logic [3:0] ef, input bit lat, input bit push);
    int   guard;
    exp_t e;
    guard    = 0;
    in_valid = 1'b1;
    a        = ta;
    b        = tb2;
    sub      = ts;
    @(negedge clk);
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      check($sformatf("accept_timeout op%0d", next_id), 64'(in_ready), 64'd1);
    end else begin
      accepts++;
      if (push) begin
        e.res   = er;
        e.fl    = ef;
        e.stamp = cyc;
        e.lat   = lat;
        e.id    = next_id;
        sb.push_back(e);
      end
    end
    next_id++;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (sb.size() > 0 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("drain", 64'(sb.size()), 64'd0);
  endtask

  // Monitor: every output transfer must match the oldest expectation
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output: got result 0x%08h flags %b, want no output", result, flags);
      end else begin
        mon_e = sb.pop_front();
        check($sformatf("op%0d result_flags", mon_e.id), {28'b0, result, flags}, {28'b0, mon_e.res, mon_e.fl});
        if (mon_e.lat)
          check($sformatf("op%0d latency", mon_e.id), 64'(cyc - mon_e.stamp), 64'd3);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  initial begin
    int base;
    int seen;

    // reset state
    #2 rst_n = 1'b0;
    @(negedge clk);
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset result", 64'(result), 64'd0);
    check("reset flags", 64'(flags), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("in_ready after reset", 64'(in_ready), 64'd1);
    @(posedge clk); #1;

    // single op, latency 3
    send(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4'b0000, 1, 1);
    in_valid = 1'b0;
    drain();
    @(posedge clk); #1;

    // back-to-back directed vectors, flags {invalid, overflow, underflow, zero}
    send(32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0000, 1, 1); // tie to even
    send(32'h3F800000, 32'h33800001, 1'b0, 32'h3F800001, 4'b0000, 1, 1); // above half
    send(32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'b0001, 1, 1); // exact cancel
    send(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b0100, 1, 1); // overflow
    send(32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 4'b1000, 1, 1); // inf - inf
    send(32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 4'b0000, 1, 1); // inf + finite
    send(32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 4'b0000, 1, 1); // 3 - 1
    send(32'h3FC00000, 32'h3FC00000, 1'b0, 32'h40400000, 4'b0000, 1, 1); // carry-out
    send(32'h3FFFFFFF, 32'h33800000, 1'b0, 32'h40000000, 4'b0000, 1, 1); // round renormalise
    send(32'h3F800000, 32'h33800000, 1'b1, 32'h3F7FFFFF, 4'b0000, 1, 1); // 1 - 2^-24
    send(32'h3F800000, 32'hBF800000, 1'b0, 32'h00000000, 4'b0001, 1, 1); // 1 + -1
    send(32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'b0001, 1, 1); // -0 + -0
    send(32'h80000000, 32'h00000000, 1'b1, 32'h80000000, 4'b0001, 1, 1); // -0 - +0
    send(32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b1000, 1, 1); // NaN in
    send(32'h00800000, 32'h00C00000, 1'b1, 32'h80000000, 4'b0011, 1, 1); // underflow
    send(32'h00000001, 32'h3F800000, 1'b0, 32'h3F800000, 4'b0000, 1, 1); // denormal flush
    send(32'h3F800000, 32'h7F800000, 1'b1, 32'hFF800000, 4'b0000, 1, 1); // finite - inf
    send(32'h3F800000, 32'h0D800000, 1'b0, 32'h3F800000, 4'b0000, 1, 1); // far shift sticky
    in_valid = 1'b0;
    drain();
    @(posedge clk); #1;

    // backpressure: five ops with the consumer stalled
    out_ready = 1'b0;
    base = accepts;
    fork
      begin
        send(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4'b0000, 0, 1);
        send(32'h40000000, 32'h40000000, 1'b0, 32'h40800000, 4'b0000, 0, 1);
        send(32'h40800000, 32'h40800000, 1'b0, 32'h41000000, 4'b0000, 0, 1);
        send(32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 4'b0000, 0, 1);
        send(32'h3FC00000, 32'h3FC00000, 1'b0, 32'h40400000, 4'b0000, 0, 1);
        in_valid = 1'b0;
      end
      begin
        int g;
        g = 0;
        @(negedge clk);
        while (!out_valid && g < 50) begin
          @(negedge clk);
          g++;
        end
        check("bp out_valid", 64'(out_valid), 64'd1);
        repeat (3) begin
          check("bp in_ready low", 64'(in_ready), 64'd0);
          check("bp held result", {28'b0, result, flags}, {28'b0, 32'h40000000, 4'b0000});
          @(negedge clk);
        end
        check("bp accepts", 64'(accepts - base), 64'd3);
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain();
    check("bp all accepted", 64'(accepts - base), 64'd5);
    @(posedge clk); #1;

    // reset with two ops in flight, the first just reaching the output
    send(32'h3F800000, 32'h3F800000, 1'b0, 32'h0, 4'b0, 0, 0);
    send(32'h40000000, 32'h40000000, 1'b0, 32'h0, 4'b0, 0, 0);
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("pre-reset out_valid", 64'(out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    check("mid reset out_valid", 64'(out_valid), 64'd0);
    check("mid reset result", 64'(result), 64'd0);
    check("mid reset flags", 64'(flags), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("in_ready after release", 64'(in_ready), 64'd1);
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("no stale output", 64'(seen), 64'd0);
    check("scoreboard empty", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
